// File: rtl/small_fifo_pkg.sv
// Shared sizing helpers for the small FWFT FIFO and its LUT-RAM store.
package small_fifo_pkg;

   function automatic int fifo_depth(input int aw);
      return 1 << aw;
   endfunction

   function automatic int count_width(input int aw);
      return aw + 1;
   endfunction

endpackage

// File: rtl/small_mem_dp.sv
// Simple dual-port distributed RAM: synchronous write, asynchronous read.
module small_mem_dp #(
   parameter int addr_width = 3,
   parameter int data_width = 9
) (
   input  logic                  CLK,
   input  logic                  WE,
   input  logic [addr_width-1:0] WA,
   input  logic [data_width-1:0] D,
   input  logic [addr_width-1:0] RA,
   output logic [data_width-1:0] O
);

   logic [data_width-1:0] mem [2**addr_width];

   always_ff @(posedge CLK) begin
      if (WE) begin
         mem[WA] <= D;
      end
   end

   assign O = mem[RA];

endmodule

// File: rtl/small_fifo.sv
// First-word-fall-through FIFO with occupancy count and sticky error flags.
module small_fifo
   import small_fifo_pkg::*;
#(
   parameter int DATA_WIDTH  = 9,
   parameter int ADDR_WIDTH  = 3,
   parameter int AFULL_LEVEL = 6
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  FLUSH,
   input  logic                  WR_EN,
   input  logic [DATA_WIDTH-1:0] WR_DATA,
   input  logic                  RD_EN,
   output logic [DATA_WIDTH-1:0] RD_DATA,
   output logic                  EMPTY,
   output logic                  FULL,
   output logic                  AFULL,
   output logic [ADDR_WIDTH:0]   COUNT,
   output logic                  OVF,
   output logic                  UDF
);

   localparam int DEPTH = fifo_depth(ADDR_WIDTH);
   localparam int CW    = count_width(ADDR_WIDTH);

   if (ADDR_WIDTH < 1) begin : g_bad_aw
      $error("small_fifo: ADDR_WIDTH must be >= 1");
   end
   if (AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH) begin : g_bad_af
      $error("small_fifo: AFULL_LEVEL out of range");
   end

   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [CW-1:0]         count;
   logic                  ovf;
   logic                  udf;
   logic                  push_ok;
   logic                  pop_ok;
   logic                  mem_we;

   // Flags come from the registered count only, never from the requests.
   assign EMPTY = (count == '0);
   assign FULL  = (count == CW'(DEPTH));
   assign AFULL = (count >= CW'(AFULL_LEVEL));
   assign COUNT = count;
   assign OVF   = ovf;
   assign UDF   = udf;

   assign push_ok = WR_EN & (~FULL | RD_EN);
   assign pop_ok  = RD_EN & ~EMPTY;
   assign mem_we  = push_ok & ~FLUSH & RST_N;

   small_mem_dp #(
      .addr_width (ADDR_WIDTH),
      .data_width (DATA_WIDTH)
   ) u_mem (
      .CLK (CLK),
      .WE  (mem_we),
      .WA  (wr_ptr),
      .D   (WR_DATA),
      .RA  (rd_ptr),
      .O   (RD_DATA)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
         udf    <= 1'b0;
      end else if (FLUSH) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
         udf    <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push_ok && !pop_ok) begin
            count <= count + 1'b1;
         end else if (pop_ok && !push_ok) begin
            count <= count - 1'b1;
         end
         if (WR_EN && !push_ok) begin
            ovf <= 1'b1;
         end
         if (RD_EN && !pop_ok) begin
            udf <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_small_fifo.sv
// Directed, table-driven checks for small_fifo at default parameters.
module tb_small_fifo;

   logic       CLK;
   logic       RST_N;
   logic       FLUSH;
   logic       WR_EN;
   logic [8:0] WR_DATA;
   logic       RD_EN;
   logic [8:0] RD_DATA;
   logic       EMPTY;
   logic       FULL;
   logic       AFULL;
   logic [3:0] COUNT;
   logic       OVF;
   logic       UDF;

   int errors = 0;
   int checks = 0;

   small_fifo dut (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .FLUSH   (FLUSH),
      .WR_EN   (WR_EN),
      .WR_DATA (WR_DATA),
      .RD_EN   (RD_EN),
      .RD_DATA (RD_DATA),
      .EMPTY   (EMPTY),
      .FULL    (FULL),
      .AFULL   (AFULL),
      .COUNT   (COUNT),
      .OVF     (OVF),
      .UDF     (UDF)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic       wr;
      logic [8:0] d;
      logic       rd;
      logic       fl;
      int         cnt;
      logic       ovf;
      logic       udf;
      logic       chk;
      logic [8:0] q;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic wr, input logic [8:0] d,
                      input logic rd, input logic fl,
                      input int cnt, input logic ovf,
                      input logic udf, input logic chk,
                      input logic [8:0] q);
      vec_t v;
      v.wr = wr; v.d = d; v.rd = rd; v.fl = fl;
      v.cnt = cnt; v.ovf = ovf; v.udf = udf;
      v.chk = chk; v.q = q;
      vecs.push_back(v);
   endtask

   // {COUNT, EMPTY, FULL, AFULL, OVF, UDF} expected for a given occupancy
   function automatic logic [8:0] flags_exp(input int cnt,
                                            input logic ovf,
                                            input logic udf);
      logic [3:0] c;
      c = 4'(cnt);
      return {c, cnt == 0, cnt == 8, cnt >= 6, ovf, udf};
   endfunction

   task automatic check_flags(input string name, input int cnt,
                              input logic ovf, input logic udf);
      logic [8:0] got;
      logic [8:0] exp;
      got = {COUNT, EMPTY, FULL, AFULL, OVF, UDF};
      exp = flags_exp(cnt, ovf, udf);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s flags cnt/e/f/af/ovf/udf got=%b exp=%b",
                  name, got, exp);
      end
   endtask

   task automatic check_data(input string name, input logic [8:0] exp);
      checks++;
      if (RD_DATA !== exp) begin
         errors++;
         $display("FAIL %s rd_data got=%h exp=%h", name, RD_DATA, exp);
      end
   endtask

   task automatic drive(input logic wr, input logic [8:0] d,
                        input logic rd, input logic fl);
      WR_EN = wr; WR_DATA = d; RD_EN = rd; FLUSH = fl;
   endtask

   initial begin
      RST_N = 1'b0;
      drive(1'b0, 9'h000, 1'b0, 1'b0);

      // A: fill 0x101..0x108, then drain in order
      for (int i = 1; i <= 8; i++)
         add(1, 9'(9'h100 + i), 0, 0, i, 0, 0, 1, 9'h101);
      for (int j = 1; j <= 8; j++)
         add(0, 0, 1, 0, 8 - j, 0, 0, j < 8, 9'(9'h101 + j));
      // B: overflow on full leaves contents intact
      for (int i = 1; i <= 8; i++)
         add(1, 9'(9'h110 + i), 0, 0, i, 0, 0, 1, 9'h111);
      add(1, 9'h1AA, 0, 0, 8, 1, 0, 1, 9'h111);
      for (int j = 1; j <= 8; j++)
         add(0, 0, 1, 0, 8 - j, 1, 0, j < 8, 9'(9'h111 + j));
      add(0, 0, 0, 1, 0, 0, 0, 0, 0);
      // C: push+pop while full, 0x055 emerges last
      for (int i = 1; i <= 8; i++)
         add(1, 9'(9'h120 + i), 0, 0, i, 0, 0, 1, 9'h121);
      add(1, 9'h055, 1, 0, 8, 0, 0, 1, 9'h122);
      for (int j = 1; j <= 6; j++)
         add(0, 0, 1, 0, 8 - j, 0, 0, 1, 9'(9'h122 + j));
      add(0, 0, 1, 0, 1, 0, 0, 1, 9'h055);
      add(0, 0, 1, 0, 0, 0, 0, 0, 0);
      // D: push+pop on empty, pop rejected
      add(1, 9'h033, 1, 0, 1, 0, 1, 1, 9'h033);
      add(0, 0, 1, 0, 0, 0, 1, 0, 0);
      // E: flush beats a concurrent push
      for (int i = 1; i <= 5; i++)
         add(1, 9'(9'h140 + i), 0, 0, i, 0, 1, 1, 9'h141);
      add(1, 9'h1FF, 0, 1, 0, 0, 0, 0, 0);
      add(1, 9'h150, 0, 0, 1, 0, 0, 1, 9'h150);
      add(0, 0, 1, 0, 0, 0, 0, 0, 0);

      #12;
      check_flags("reset", 0, 0, 0);
      RST_N = 1'b1;

      foreach (vecs[k]) begin
         drive(vecs[k].wr, vecs[k].d, vecs[k].rd, vecs[k].fl);
         @(posedge CLK);
         #1;
         check_flags($sformatf("vec%0d", k), vecs[k].cnt,
                     vecs[k].ovf, vecs[k].udf);
         if (vecs[k].chk)
            check_data($sformatf("vec%0d", k), vecs[k].q);
      end

      // Asynchronous reset in the middle of a cycle at COUNT=3
      for (int i = 1; i <= 3; i++) begin
         drive(1'b1, 9'(9'h160 + i), 1'b0, 1'b0);
         @(posedge CLK);
         #1;
      end
      check_flags("pre_rst", 3, 0, 0);
      check_data("pre_rst", 9'h161);
      #2;
      RST_N = 1'b0;
      #1;
      check_flags("async_rst", 0, 0, 0);
      drive(1'b1, 9'h1EE, 1'b1, 1'b0);
      @(posedge CLK);
      #1;
      check_flags("rst_held", 0, 0, 0);
      @(negedge CLK);
      RST_N = 1'b1;
      drive(1'b1, 9'h170, 1'b0, 1'b0);
      @(posedge CLK);
      #1;
      check_flags("post_rst", 1, 0, 0);
      check_data("post_rst", 9'h170);
      drive(1'b0, 9'h000, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/small_fifo.md
Name: small_fifo

Overview:
- Parametrised first-word-fall-through (FWFT) FIFO built on a distributed-RAM style store: synchronous write, asynchronous read.
- Next generation of the team's small single-port LUT memory: adds separate read/write pointers, occupancy tracking, full/empty/almost-full flags, flush, and sticky error flags.
- Intended for short elastic buffers between OR1200-side Wishbone logic and peripherals (UART, JPEG, DVGA).

Parameters:
- DATA_WIDTH, 9, width of each stored word.
- ADDR_WIDTH, 3, log2 of depth; DEPTH = 2**ADDR_WIDTH, minimum ADDR_WIDTH = 1.
- AFULL_LEVEL, 6, AFULL asserts when COUNT >= AFULL_LEVEL; legal range 1..DEPTH.

Ports:
- CLK  in  1  system clock; all state updates on its rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- FLUSH  in  1  synchronous clear of contents and sticky flags.
- WR_EN  in  1  push request.
- WR_DATA  in  DATA_WIDTH  push data.
- RD_EN  in  1  pop request; acknowledges the word currently on RD_DATA.
- RD_DATA  out  DATA_WIDTH  head word, combinational from storage; valid only while EMPTY=0.
- EMPTY  out  1  COUNT == 0.
- FULL  out  1  COUNT == DEPTH.
- AFULL  out  1  COUNT >= AFULL_LEVEL.
- COUNT  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- OVF  out  1  sticky: a push was rejected.
- UDF  out  1  sticky: a pop was rejected.

Behaviour:
- Reset (RST_N low, asynchronous):
  - wr_ptr, rd_ptr and COUNT go to 0.
  - EMPTY=1, FULL=0, AFULL=0, OVF=0, UDF=0.
  - Storage is not reset; RD_DATA is undefined while EMPTY=1.
- Flag timing: EMPTY, FULL and AFULL are decoded from the registered COUNT only. They never depend combinationally on WR_EN or RD_EN.
- Accept rules, evaluated on the pre-edge state:
  - push_ok = WR_EN & (~FULL | RD_EN). A push into a full FIFO is accepted only when a pop occurs in the same cycle.
  - pop_ok = RD_EN & ~EMPTY. A pop on an empty FIFO is rejected even if a push occurs in the same cycle; there is no write-to-read bypass.
- On push_ok: storage[wr_ptr] <= WR_DATA; wr_ptr increments modulo DEPTH.
- On pop_ok: rd_ptr increments modulo DEPTH.
- COUNT update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged when both or neither occur.
- Full-with-simultaneous-pop: wr_ptr == rd_ptr. RD_DATA shows the old head during the cycle, and the new word overwrites that slot at the edge. This is legal because the read is asynchronous and the write is synchronous.
- Latency:
  - A word pushed into an empty FIFO appears on RD_DATA, with EMPTY=0, in the cycle after the push edge.
  - After a pop, RD_DATA shows the next word in the cycle after the pop edge.
- Errors:
  - WR_EN & ~push_ok sets OVF; contents, pointers and COUNT are unchanged.
  - RD_EN & ~pop_ok sets UDF.
  - Both flags hold until FLUSH or reset.
- FLUSH has priority over push, pop and error detection in the same cycle. It clears pointers, COUNT, OVF and UDF, and leaves storage contents stale.
- Wrap-around: pointers are ADDR_WIDTH bits and wrap naturally. Full/empty disambiguation comes from COUNT, not from pointer equality.
- Reset asserted mid-operation: immediate return to the reset state. Pending requests are discarded; no partial write beyond the current edge.

Decomposition:
- Shared package/include: DEPTH derivation from ADDR_WIDTH and the COUNT width (ADDR_WIDTH+1).
- One sub-module, small_mem_dp:
  - Simple dual-port distributed RAM.
  - Write port: WA, D, WE; synchronous write.
  - Read port: RA; asynchronous read.
  - Parameters: addr_width, data_width.
- Pointer, count and flag logic stay in small_fifo.

Test Plan:
- Reset with defaults -> EMPTY=1, FULL=0, AFULL=0, COUNT=0, OVF=0, UDF=0.
- Push 0x101..0x108 (8 writes) -> AFULL rises when COUNT=6; FULL=1 at COUNT=8; pops then return 0x101..0x108 in order.
- Fill to 8, then assert WR_EN with 0x1AA and no RD_EN -> OVF=1, COUNT stays 8, pop sequence is unchanged.
- Full FIFO with WR_EN=1 (0x055) and RD_EN=1 together -> COUNT stays 8, FULL stays 1, 0x055 emerges last after 7 further pops; pointers wrap cleanly.
- Empty FIFO with RD_EN=1 and WR_EN=1 (0x033) together -> UDF=1, COUNT=1, RD_DATA=0x033 in the next cycle.
- Hold 5 words, pulse FLUSH together with WR_EN -> COUNT=0, EMPTY=1, OVF=0, UDF=0. Separately, drop RST_N between clock edges while at COUNT=3 -> outputs go to reset values immediately.
